multicycle_controller: RTL and testbench

- Multi-cycle sequencer for the 8-bit, four-register CPU.
- Owns the PC and drives the instruction memory read address.
- Latches each fetched instruction word into an internal IR and decodes it.
- Steps the register file, ALU and data memory through fetch/decode/execute/memory/writeback, with a ready handshake to data memory.

---
 rtl/multicycle_controller_if.sv | 46 ++++
 rtl/multicycle_controller.sv | 174 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction/data-memory and control bundle for the multi-cycle controller
//
// Purpose: groups the run control, instruction fetch, data-memory handshake and
// datapath control signals of the 8-bit four-register CPU sequencer.
// Ports (signals):
//   Run, Instruction[7:0], Mem_Ready         - environment -> controller
//   Read_Address[PC_WIDTH-1:0]                - instruction memory address (PC)
//   Rs, Rt, Rd [1:0], Imm[7:0]                - decoded IR fields
//   ALU_Src, Mem_Read, Mem_Write, Reg_Write,
//   Reg_Dst, Mem_To_Reg, Halted               - Moore control outputs
//   Instr_Count[PC_WIDTH-1:0]                 - retired instruction count
// Modports: master = controller side, slave = memory/datapath side.
interface multicycle_controller_if #(
    parameter int PC_WIDTH = 8
);
    logic                Run;
    logic [7:0]          Instruction;
    logic                Mem_Ready;
    logic [PC_WIDTH-1:0] Read_Address;
    logic [1:0]          Rs;
    logic [1:0]          Rt;
    logic [1:0]          Rd;
    logic [7:0]          Imm;
    logic                ALU_Src;
    logic                Mem_Read;
    logic                Mem_Write;
    logic                Reg_Write;
    logic                Reg_Dst;
    logic                Mem_To_Reg;
    logic                Halted;
    logic [PC_WIDTH-1:0] Instr_Count;

    modport master (
        input  Run, Instruction, Mem_Ready,
        output Read_Address, Rs, Rt, Rd, Imm,
        output ALU_Src, Mem_Read, Mem_Write, Reg_Write, Reg_Dst, Mem_To_Reg,
        output Halted, Instr_Count
    );

    modport slave (
        output Run, Instruction, Mem_Ready,
        input  Read_Address, Rs, Rt, Rd, Imm,
        input  ALU_Src, Mem_Read, Mem_Write, Reg_Write, Reg_Dst, Mem_To_Reg,
        input  Halted, Instr_Count
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer
//
// Purpose: owns the PC and IR of the 8-bit four-register CPU, decodes
// add/lw/sw/j and steps the datapath through IDLE, FETCH, DECODE, EXEC, MEM,
// WB and HALT. A self-jump parks the controller in HALT until reset.
// Ports:
//   Clk      - system clock, rising edge
//   Reset_n  - asynchronous active-low reset
//   bus      - multicycle_controller_if.master (see interface file)
module multicycle_controller #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    multicycle_controller_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]          ir_q, ir_d;

    logic alu_src_q,    alu_src_d;
    logic mem_read_q,   mem_read_d;
    logic mem_write_q,  mem_write_d;
    logic reg_write_q,  reg_write_d;
    logic reg_dst_q,    reg_dst_d;
    logic mem_to_reg_q, mem_to_reg_d;
    logic halted_q,     halted_d;

    logic [1:0]          op_q, op_d;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] j_target;
    logic                retire;

    assign op_q     = ir_q[7:6];
    assign op_d     = ir_d[7:6];
    assign pc_inc   = pc_q + PC_WIDTH'(1);
    // Jump offset is IR[1:0] as a signed 2-bit value, relative to PC+1.
    assign j_target = pc_inc + {{(PC_WIDTH-2){ir_q[1]}}, ir_q[1:0]};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        retire  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = bus.Instruction;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (op_q == OP_J) begin
                    if (j_target == pc_q) begin
                        // Self-jump retires but never leaves HALT.
                        cnt_d   = cnt_q + PC_WIDTH'(1);
                        state_d = S_HALT;
                    end else begin
                        pc_d   = j_target;
                        retire = 1'b1;
                    end
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = (op_q == OP_ADD) ? S_WB : S_MEM;
            end
            S_MEM: begin
                if (bus.Mem_Ready) begin
                    if (op_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        pc_d   = pc_inc;
                        retire = 1'b1;
                    end
                end
            end
            S_WB: begin
                pc_d   = pc_inc;
                retire = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (retire) begin
            cnt_d   = cnt_q + PC_WIDTH'(1);
            state_d = bus.Run ? S_FETCH : S_IDLE;
        end
    end

    // Control outputs are registered from the next state/IR so that each one
    // is a clean Moore function of the state actually occupied.
    always_comb begin
        alu_src_d    = (state_d == S_MEM) || ((state_d == S_EXEC) && (op_d != OP_ADD));
        mem_read_d   = (state_d == S_MEM) && (op_d == OP_LW);
        mem_write_d  = (state_d == S_MEM) && (op_d == OP_SW);
        reg_write_d  = (state_d == S_WB);
        reg_dst_d    = (state_d == S_WB) && (op_d == OP_ADD);
        mem_to_reg_d = (state_d == S_WB) && (op_d == OP_LW);
        halted_d     = (state_d == S_HALT);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            cnt_q        <= '0;
            ir_q         <= '0;
            alu_src_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            ir_q         <= ir_d;
            alu_src_q    <= alu_src_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            reg_dst_q    <= reg_dst_d;
            mem_to_reg_q <= mem_to_reg_d;
            halted_q     <= halted_d;
        end
    end

    assign bus.Read_Address = pc_q;
    assign bus.Instr_Count  = cnt_q;
    assign bus.Rs           = ir_q[5:4];
    assign bus.Rt           = ir_q[3:2];
    assign bus.Rd           = ir_q[1:0];
    assign bus.Imm          = {{6{ir_q[1]}}, ir_q[1:0]};
    assign bus.ALU_Src      = alu_src_q;
    assign bus.Mem_Read     = mem_read_q;
    assign bus.Mem_Write    = mem_write_q;
    assign bus.Reg_Write    = reg_write_q;
    assign bus.Reg_Dst      = reg_dst_q;
    assign bus.Mem_To_Reg   = mem_to_reg_q;
    assign bus.Halted       = halted_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

    localparam int NMAX = 1100;

    localparam logic [6:0] C_ALU = 7'b1000000;
    localparam logic [6:0] C_RD  = 7'b0100000;
    localparam logic [6:0] C_WR  = 7'b0010000;
    localparam logic [6:0] C_RW  = 7'b0001000;
    localparam logic [6:0] C_DST = 7'b0000100;
    localparam logic [6:0] C_M2R = 7'b0000010;
    localparam logic [6:0] C_HLT = 7'b0000001;

    logic clk;
    logic reset_n;

    logic [7:0]  imem  [256];
    logic        rdy   [NMAX];
    logic        run_a [NMAX];
    logic [36:0] e_vec [NMAX];
    logic [36:0] o_hist[NMAX];
    int          cur_nc;

    int errors = 0;
    int checks = 0;

    multicycle_controller_if #(.PC_WIDTH(8)) bus ();

    multicycle_controller #(
        .PC_WIDTH(8),
        .RESET_PC(8'h00)
    ) dut (
        .Clk    (clk),
        .Reset_n(reset_n),
        .bus    (bus)
    );

    assign bus.Instruction = imem[bus.Read_Address];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [36:0] mkvec(input logic [7:0] pc, input logic [7:0] cnt,
                                          input logic [6:0] ctl, input logic [7:0] ir);
        return {pc, cnt, ctl, ir[5:4], ir[3:2], ir[1:0], {6{ir[1]}}, ir[1:0]};
    endfunction

    function automatic logic [36:0] observe();
        return {bus.Read_Address, bus.Instr_Count,
                bus.ALU_Src, bus.Mem_Read, bus.Mem_Write, bus.Reg_Write,
                bus.Reg_Dst, bus.Mem_To_Reg, bus.Halted,
                bus.Rs, bus.Rt, bus.Rd, bus.Imm};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_exp(input int idx, input logic [7:0] pc, input logic [6:0] ctl,
                           input logic [7:0] cnt, input logic [7:0] ir);
        if (idx < cur_nc) e_vec[idx] = mkvec(pc, cnt, ctl, ir);
    endtask

    // Instruction-level reference: walks the program with the ISA rules and the
    // published latencies (add 4, lw 5+wait, sw 4+wait, j 2) to lay out the
    // expected per-cycle output trace. Cycle 0 is the first cycle after reset.
    task automatic build_model(input int nc);
        logic [7:0] pc, cnt, ins, prev, tgt;
        logic [6:0] m;
        int c, k, r, t;
        bit done;
        cur_nc = nc;
        pc = 8'h00; cnt = 8'h00; prev = 8'h00; done = 1'b0; r = 0;
        set_exp(0, pc, 7'd0, cnt, prev);
        while (!done) begin
            t = r;
            while (t < nc && !run_a[t]) begin
                t++;
                set_exp(t, pc, 7'd0, cnt, prev);
            end
            c = t + 1;
            if (c >= nc) begin
                done = 1'b1;
            end else begin
                ins = imem[pc];
                set_exp(c, pc, 7'd0, cnt, prev);
                set_exp(c + 1, pc, 7'd0, cnt, ins);
                case (ins[7:6])
                    2'b11: begin
                        tgt = pc + 8'd1 + {{6{ins[1]}}, ins[1:0]};
                        cnt = cnt + 8'd1;
                        if (tgt == pc) begin
                            for (int h = c + 2; h < nc; h++) set_exp(h, pc, C_HLT, cnt, ins);
                            done = 1'b1;
                        end else begin
                            pc = tgt;
                            r  = c + 1;
                        end
                    end
                    2'b00: begin
                        set_exp(c + 2, pc, 7'd0, cnt, ins);
                        set_exp(c + 3, pc, C_RW | C_DST, cnt, ins);
                        pc = pc + 8'd1; cnt = cnt + 8'd1; r = c + 3;
                    end
                    default: begin
                        m = (ins[7:6] == 2'b01) ? C_RD : C_WR;
                        set_exp(c + 2, pc, C_ALU, cnt, ins);
                        k = c + 3;
                        while (k < nc && !rdy[k]) begin
                            set_exp(k, pc, C_ALU | m, cnt, ins);
                            k++;
                        end
                        set_exp(k, pc, C_ALU | m, cnt, ins);
                        if (ins[7:6] == 2'b01) begin
                            set_exp(k + 1, pc, C_RW | C_M2R, cnt, ins);
                            r = k + 1;
                        end else begin
                            r = k;
                        end
                        pc = pc + 8'd1; cnt = cnt + 8'd1;
                    end
                endcase
                prev = ins;
            end
        end
    endtask

    task automatic run_check(input int nc, input string tag);
        build_model(nc);
        reset_n       = 1'b0;
        bus.Run       = 1'b0;
        bus.Mem_Ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < nc; n++) begin
            o_hist[n] = observe();
            chk($sformatf("%s_cyc%0d", tag, n), 64'(o_hist[n]), 64'(e_vec[n]));
            bus.Run       = run_a[n];
            bus.Mem_Ready = rdy[n];
            @(negedge clk);
        end
    endtask

    task automatic fill_stim(input logic [7:0] ins, input logic r, input logic go);
        for (int i = 0; i < 256; i++) imem[i] = ins;
        for (int i = 0; i < NMAX; i++) begin
            rdy[i]   = r;
            run_a[i] = go;
        end
    endtask

    initial begin
        int n_rd, n_wr, n_rw, rw_at;
        logic [7:0] b;
        reset_n       = 1'b0;
        bus.Run       = 1'b0;
        bus.Mem_Ready = 1'b0;
        cur_nc        = 0;
        fill_stim(8'h00, 1'b1, 1'b1);

        // Reset state while held in reset.
        #2;
        chk("reset_addr",   64'(bus.Read_Address), 64'h00);
        chk("reset_cnt",    64'(bus.Instr_Count),  64'h00);
        chk("reset_halted", 64'(bus.Halted),       64'h0);
        chk("reset_ctl",    64'({bus.ALU_Src, bus.Mem_Read, bus.Mem_Write, bus.Reg_Write,
                                 bus.Reg_Dst, bus.Mem_To_Reg}), 64'h0);

        // Small program with memory always ready.
        fill_stim(8'hC3, 1'b1, 1'b1);
        imem[0] = 8'h50; imem[1] = 8'h59; imem[2] = 8'h18; imem[3] = 8'h99; imem[4] = 8'hC3;
        run_check(30, "prog");
        n_rd = 0; n_wr = 0; n_rw = 0;
        for (int i = 0; i < 30; i++) begin
            n_rd += int'(o_hist[i][19]);
            n_wr += int'(o_hist[i][18]);
            n_rw += int'(o_hist[i][17]);
        end
        chk("prog_regwrite_pulses", 64'(n_rw), 64'd3);
        chk("prog_memwrite_pulses", 64'(n_wr), 64'd1);
        chk("prog_memread_pulses",  64'(n_rd), 64'd2);
        chk("prog_halted",          64'(o_hist[29][14]),    64'h1);
        chk("prog_halt_pc",         64'(o_hist[29][36:29]), 64'h04);
        chk("prog_halt_cnt",        64'(o_hist[29][28:21]), 64'h05);

        // lw with three not-ready cycles: MEM spans cycles 4..7.
        fill_stim(8'hC3, 1'b1, 1'b1);
        imem[0] = 8'h54;
        rdy[4] = 1'b0; rdy[5] = 1'b0; rdy[6] = 1'b0;
        run_check(14, "lwwait");
        n_rd = 0; n_rw = 0; rw_at = -1;
        for (int i = 0; i < 14; i++) begin
            n_rd += int'(o_hist[i][19]);
            n_rw += int'(o_hist[i][17]);
            if (o_hist[i][17] && rw_at < 0) rw_at = i;
        end
        chk("lwwait_memread_cycles", 64'(n_rd), 64'd4);
        chk("lwwait_regwrite_pulses", 64'(n_rw), 64'd1);
        chk("lwwait_regwrite_cycle", 64'(rw_at), 64'd8);

        // Forward jump by +2 from PC 0x10 after sixteen adds.
        fill_stim(8'h00, 1'b1, 1'b1);
        imem[8'h10] = 8'hC1;
        imem[8'h12] = 8'hC3;
        run_check(68, "jump");
        chk("jump_pc_before", 64'(o_hist[66][36:29]), 64'h10);
        chk("jump_pc_after",  64'(o_hist[67][36:29]), 64'h12);
        chk("jump_not_halted", 64'(o_hist[67][14]),   64'h0);

        // 256 adds: PC and Instr_Count both wrap on the add at 0xFF.
        fill_stim(8'h1B, 1'b1, 1'b1);
        run_check(1026, "wrap");
        chk("wrap_pc_ff",  64'(o_hist[1024][36:29]), 64'hFF);
        chk("wrap_cnt_ff", 64'(o_hist[1024][28:21]), 64'hFF);
        chk("wrap_pc_00",  64'(o_hist[1025][36:29]), 64'h00);
        chk("wrap_cnt_00", 64'(o_hist[1025][28:21]), 64'h00);

        // Run dropped during a sw: parks in IDLE, resumes at the next PC.
        fill_stim(8'hC3, 1'b1, 1'b1);
        imem[0] = 8'h99; imem[1] = 8'h00;
        for (int i = 3; i < 10; i++) run_a[i] = 1'b0;
        run_check(20, "rundrop");
        chk("rundrop_parked_pc",  64'(o_hist[8][36:29]),  64'h01);
        chk("rundrop_parked_ctl", 64'(o_hist[8][20:14]),  64'h00);
        chk("rundrop_resume_cnt", 64'(o_hist[15][28:21]), 64'h02);

        // Randomized programs, memory latency and Run.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) begin
                b = 8'($urandom_range(0, 255));
                if (b[7:6] == 2'b11 && b[1:0] == 2'b11 && $urandom_range(0, 7) != 0) b[1:0] = 2'b01;
                imem[i] = b;
            end
            for (int i = 0; i < NMAX; i++) begin
                rdy[i]   = ($urandom_range(0, 2) != 0);
                run_a[i] = ($urandom_range(0, 9) != 0);
            end
            run_check(1000, $sformatf("rand%0d", s));
        end

        // Asynchronous reset during a stalled sw in MEM.
        fill_stim(8'hC3, 1'b0, 1'b1);
        imem[0] = 8'h00; imem[1] = 8'h99;
        run_check(10, "amem");
        chk("amem_pre_memwrite", 64'(bus.Mem_Write),    64'h1);
        chk("amem_pre_pc",       64'(bus.Read_Address), 64'h01);
        #2 reset_n = 1'b0;
        #1;
        chk("amem_memwrite_clear", 64'(bus.Mem_Write),    64'h0);
        chk("amem_pc_clear",       64'(bus.Read_Address), 64'h00);
        chk("amem_alusrc_clear",   64'(bus.ALU_Src),      64'h0);
        chk("amem_cnt_clear",      64'(bus.Instr_Count),  64'h00);
        @(negedge clk);
        chk("amem_held_idle_ctl", 64'({bus.ALU_Src, bus.Mem_Read, bus.Mem_Write, bus.Reg_Write,
                                       bus.Halted}), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
